shifter_cfg_loader: RTL and testbench
=====================================

Name: shifter_cfg_loader

Overview:
- Host-side transmitter for the 12-bit configuration shift chain: accepts a parallel config word and serialises it onto the shift_clk/shift_dta pins that load the oscillator-enable shifter.
- Generates shift_clk from clk with a programmable half-period and presents data MSB-first, so the receiving chain holds shifter[WIDTH-1:0] == cfg_data after the last edge.
- Sits on the stimulus/controller side, driving the user module's io_in[2] and io_in[3].

Parameters:
- WIDTH, 12, number of bits per load; must equal the receiving shifter length.
- HALF, 2, shift_clk half-period in clk cycles; legal range is >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-high (asserted = 1)
- cfg_valid  input  1  request to load cfg_data
- cfg_ready  output  1  block can accept a word; high only in IDLE
- cfg_data  input  WIDTH  word to load; captured on accept
- shift_clk  output  1  serial clock to the chain; the receiver samples on its rising edge
- shift_dta  output  1  serial data, valid across each shift_clk rising edge
- busy  output  1  high from the accept edge until DONE ends
- done  output  1  one-cycle pulse when the last bit has been clocked

Behaviour:
- Reset value of every output: cfg_ready=1, shift_clk=0, shift_dta=0, busy=0, done=0. Internal FSM=IDLE, bit index=0, phase counter=0.
- Reset mid-operation aborts immediately. No partial-word completion and no done pulse.
- All outputs are registered. shift_clk is never glitched or gated.
- FSM states: IDLE, SETUP, PULSE, DONE.
- IDLE:
  - On cfg_valid && cfg_ready at edge E0: latch cfg_data into sreg, set bit index=WIDTH-1.
  - At the same edge: shift_dta<=cfg_data[WIDTH-1], shift_clk<=0, busy<=1, go to SETUP.
- SETUP (shift_clk low, data stable): stay HALF cycles, then shift_clk<=1 and go to PULSE.
- PULSE (shift_clk high, data unchanged): stay HALF cycles.
  - If bit index==0: shift_clk<=0, shift_dta<=0, done<=1, go to DONE.
  - Else: decrement bit index, shift_dta<=sreg[next index], shift_clk<=0, go to SETUP.
  - shift_dta therefore changes only on shift_clk falling transitions.
- DONE: lasts one cycle; done=1, busy=1, cfg_ready=0. Then go to IDLE with done<=0, busy<=0, cfg_ready<=1.
- Cycle budget:
  - First shift_clk rise occurs HALF cycles after E0.
  - Exactly WIDTH rising edges per word.
  - done is asserted 2*HALF*WIDTH cycles after E0.
  - Next accept is possible at the cycle after DONE.
- Boundary conditions:
  - cfg_valid while busy is ignored; the word is not queued.
  - cfg_data changes after accept have no effect.
  - cfg_valid held high continuously gives back-to-back loads with exactly one IDLE cycle between them.
  - The phase counter is ceil(log2(HALF+1)) bits wide and wraps to 0 at each phase change.
  - HALF=1 yields shift_clk = clk/2.

Optional Feature:
- Macro: SHIFTER_READBACK_EN.
- With the macro defined, the block adds:
  - input shift_ret (1 bit), driven from the far end of the chain (shifter[WIDTH-1]).
  - output rd_data (WIDTH bits), reset to 0.
  - output rd_valid (1 bit), reset to 0.
- Capture: on the last clk cycle of each SETUP phase, shift_ret is shifted into rd_data LSB-first-in. After WIDTH bits, rd_data holds the chain contents from before the load.
- rd_valid pulses together with done. rd_data holds its value until the next accept, which clears it.
- Without the macro: none of these ports or that logic exist, and behaviour is otherwise identical.

Test Plan:
- Reset then idle (WIDTH=12, HALF=2) -> cfg_ready=1, shift_clk=0, shift_dta=0, busy=0, done=0.
- Load 12'hA5C with HALF=2 -> 12 shift_clk rises, first at E0+2, period 4 cycles. Bits sampled at the rises are 1,0,1,0,0,1,0,1,1,1,0,0. done at E0+48 for one cycle. A model shifter reads 12'hA5C.
- cfg_valid held high with words 12'hFFF then 12'h001 -> second accept exactly 1 cycle after done. Model shifter ends at 12'h001. cfg_data toggled while busy has no effect.
- HALF=1, load 12'h800 -> shift_clk is clk/2, shift_dta=1 only during the first bit, done at E0+24.
- rst_n asserted at E0+17 mid-load -> outputs return to reset values asynchronously, no done pulse, and a new load accepted after release completes normally.
- SHIFTER_READBACK_EN: preload the model chain with 12'h3C6, then load 12'h000 -> rd_data=12'h3C6 and rd_valid pulses with done.

Source files
------------

// File: rtl/shifter_cfg_loader.sv
// shifter_cfg_loader: serialises a parallel config word MSB-first onto the
// shift_clk/shift_dta pins of the oscillator-enable shift chain.
// Optional build macro: SHIFTER_READBACK_EN adds shift_ret/rd_data/rd_valid
// to capture the chain's previous contents while a new word is loaded.
// Reset: rst_n is asynchronous and active-high (asserted = 1).
module shifter_cfg_loader #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned HALF  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             shift_clk,
  output logic             shift_dta,
  output logic             busy,
  output logic             done
`ifdef SHIFTER_READBACK_EN
  ,
  input  logic             shift_ret,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
`endif
);

  localparam int unsigned PW = (HALF + 1 > 2) ? $clog2(HALF + 1) : 1;
  localparam int unsigned IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [PW-1:0]    phase, phase_d;
  logic [IW-1:0]    idx, idx_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic             ready_d, sclk_d, sdta_d, busy_d, done_d;
  logic             phase_end;

  assign phase_end = (phase == PW'(HALF - 1));

`ifdef SHIFTER_READBACK_EN
  logic [WIDTH-1:0] rd_data_d;
`endif

  // Next-state and next-output decode
  always_comb begin
    state_d = state;
    phase_d = phase;
    idx_d   = idx;
    sreg_d  = sreg;
    ready_d = cfg_ready;
    sclk_d  = shift_clk;
    sdta_d  = shift_dta;
    busy_d  = busy;
    done_d  = 1'b0;
`ifdef SHIFTER_READBACK_EN
    rd_data_d = rd_data;
`endif
    unique case (state)
      IDLE: begin
        if (cfg_valid && cfg_ready) begin
          sreg_d  = cfg_data;
          idx_d   = IW'(WIDTH - 1);
          sdta_d  = cfg_data[WIDTH-1];
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          phase_d = '0;
          state_d = SETUP;
`ifdef SHIFTER_READBACK_EN
          rd_data_d = '0;
`endif
        end
      end
      SETUP: begin
        if (phase_end) begin
          phase_d = '0;
          sclk_d  = 1'b1;
          state_d = PULSE;
`ifdef SHIFTER_READBACK_EN
          // Far end of the chain is sampled just before it shifts on this rise
          rd_data_d = {rd_data[WIDTH-2:0], shift_ret};
`endif
        end else begin
          phase_d = phase + PW'(1);
        end
      end
      PULSE: begin
        if (phase_end) begin
          phase_d = '0;
          sclk_d  = 1'b0;
          if (idx == '0) begin
            sdta_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx - IW'(1);
            sdta_d  = sreg[idx_d];
            state_d = SETUP;
          end
        end else begin
          phase_d = phase + PW'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= IDLE;
      phase     <= '0;
      idx       <= '0;
      sreg      <= '0;
      cfg_ready <= 1'b1;
      shift_clk <= 1'b0;
      shift_dta <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      idx       <= idx_d;
      sreg      <= sreg_d;
      cfg_ready <= ready_d;
      shift_clk <= sclk_d;
      shift_dta <= sdta_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

`ifdef SHIFTER_READBACK_EN
  // Readback capture register and its completion pulse
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_data  <= rd_data_d;
      rd_valid <= done_d;
    end
  end
`endif

endmodule

// File: tb/tb_shifter_cfg_loader.sv
// Bench for shifter_cfg_loader: a HALF=2 and a HALF=1 instance, each with a
// receiving chain model, checked every cycle against a cycle-count model.
module tb_shifter_cfg_loader;

  localparam int unsigned W = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         v   [2];
  logic [W-1:0] d   [2];
  logic         rdy [2];
  logic         sck [2];
  logic         sdt [2];
  logic         bsy [2];
  logic         dn  [2];
  logic [W-1:0] rdd [2];
  logic         rdv [2];

  logic [W-1:0] chain0, chain1;
  logic [W-1:0] pre_val;
  logic         pre_ld = 1'b0;

  shifter_cfg_loader #(.WIDTH(W), .HALF(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(v[0]), .cfg_ready(rdy[0]),
    .cfg_data(d[0]), .shift_clk(sck[0]), .shift_dta(sdt[0]),
    .busy(bsy[0]), .done(dn[0])
`ifdef SHIFTER_READBACK_EN
    , .shift_ret(chain0[W-1]), .rd_data(rdd[0]), .rd_valid(rdv[0])
`endif
  );

  shifter_cfg_loader #(.WIDTH(W), .HALF(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(v[1]), .cfg_ready(rdy[1]),
    .cfg_data(d[1]), .shift_clk(sck[1]), .shift_dta(sdt[1]),
    .busy(bsy[1]), .done(dn[1])
`ifdef SHIFTER_READBACK_EN
    , .shift_ret(chain1[W-1]), .rd_data(rdd[1]), .rd_valid(rdv[1])
`endif
  );

`ifndef SHIFTER_READBACK_EN
  initial begin
    rdd[0] = '0; rdd[1] = '0; rdv[0] = 1'b0; rdv[1] = 1'b0;
  end
`endif

  // Receiving chains: shift on the serial clock rise, preloadable by the bench
  always @(posedge sck[0] or posedge pre_ld)
    if (pre_ld) chain0 <= pre_val;
    else        chain0 <= {chain0[W-2:0], sdt[0]};

  always @(posedge sck[1] or posedge pre_ld)
    if (pre_ld) chain1 <= pre_val;
    else        chain1 <= {chain1[W-1-1:0], sdt[1]};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int hf(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Model: c = clk edges since accept (-1 when idle)
  int           c   [2] = '{-1, -1};
  logic [W-1:0] wd  [2];
  logic [W-1:0] snap[2];
  int           acc [2] = '{0, 0};
  int           cyc = 0;

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      c[0] = -1;
      c[1] = -1;
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (c[i] < 0) begin
          if (v[i] === 1'b1) begin
            c[i]    = 0;
            wd[i]   = d[i];
            snap[i] = (i == 0) ? chain0 : chain1;
            acc[i]  = cyc;
          end
        end else begin
          c[i]++;
          if (c[i] > 2 * hf(i) * int'(W)) c[i] = -1;
        end
      end
    end
  end

  int           done_cyc [2] = '{0, 0};
  logic [W-1:0] rd_done  [2];

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int h, n, bi;
      logic [4:0] e, a;
      logic [W-1:0] ch;
      h  = hf(i);
      n  = 2 * h * int'(W);
      ch = (i == 0) ? chain0 : chain1;
      if (c[i] < 0) e = 5'b10000;
      else if (c[i] < n) begin
        bi = int'(W) - 1 - c[i] / (2 * h);
        e  = {1'b0, ((c[i] / h) % 2) == 1, wd[i][bi], 1'b1, 1'b0};
      end else e = 5'b00011;
      a = {rdy[i], sck[i], sdt[i], bsy[i], dn[i]};
      chk($sformatf("dut%0d_rdy_sck_dta_busy_done", i), 32'(a), 32'(e));
      if (c[i] == n) begin
        chk($sformatf("dut%0d_chain_at_done", i), 32'(ch), 32'(wd[i]));
        done_cyc[i] = cyc;
        rd_done[i]  = rdd[i];
      end
`ifdef SHIFTER_READBACK_EN
      chk($sformatf("dut%0d_rd_valid", i), 32'(rdv[i]), 32'(c[i] == n));
      if (c[i] == 0) chk($sformatf("dut%0d_rd_clear", i), 32'(rdd[i]), 32'(0));
      if (c[i] == n) chk($sformatf("dut%0d_rd_data", i), 32'(rdd[i]), 32'(snap[i]));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load one word on instance i; optionally scramble cfg_data while busy
  task automatic load(input int i, input logic [W-1:0] w, input bit tog);
    int k;
    k = 0;
    v[i] = 1'b1;
    d[i] = w;
    do begin step(); k++; end while (c[i] != 0 && k < 100);
    v[i] = 1'b0;
    chk("accept_bound", 32'(k < 100), 32'(1));
    while (c[i] >= 0 && k < 400) begin
      if (tog) d[i] = W'($urandom);
      step();
      k++;
    end
    chk("done_bound", 32'(k < 400), 32'(1));
  endtask

  int k, a1;

  initial begin
    rst_n = 1'b1;
    v[0] = 1'b0; v[1] = 1'b0;
    d[0] = '0;   d[1] = '0;
    pre_val = '0;
    #2 pre_ld = 1'b1;
    #1 pre_ld = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_outs", 32'({rdy[0], sck[0], sdt[0], bsy[0], dn[0]}), 32'(5'b10000));
    step();
    rst_n = 1'b0;
    repeat (2) step();

    // Directed load with the worked example word
    load(0, 12'hA5C, 1'b1);
    chk("a5c_latency", 32'(done_cyc[0] - acc[0]), 32'(48));
    chk("a5c_chain", 32'(chain0), 32'(12'hA5C));

    // Held-valid back-to-back loads; data scrambled while busy
    k = 0;
    v[0] = 1'b1;
    d[0] = 12'hFFF;
    do begin step(); k++; end while (c[0] != 0 && k < 100);
    a1 = acc[0];
    while (c[0] >= 0 && k < 400) begin
      d[0] = (c[0] >= 40) ? 12'h001 : W'($urandom);
      step();
      k++;
    end
    chk("fff_latency", 32'(done_cyc[0] - a1), 32'(48));
    do begin step(); k++; end while (c[0] != 0 && k < 400);
    chk("b2b_gap", 32'(acc[0] - done_cyc[0]), 32'(2));
    v[0] = 1'b0;
    while (c[0] >= 0 && k < 400) begin d[0] = W'($urandom); step(); k++; end
    chk("b2b_bound", 32'(k < 400), 32'(1));
    chk("b2b_chain", 32'(chain0), 32'(12'h001));

    // HALF=1 instance
    load(1, 12'h800, 1'b1);
    chk("h1_latency", 32'(done_cyc[1] - acc[1]), 32'(24));
    chk("h1_chain", 32'(chain1), 32'(12'h800));

    // Reset asserted mid-load at E0+17
    v[0] = 1'b1;
    d[0] = 12'h5A3;
    k = 0;
    do begin step(); k++; end while (c[0] != 0 && k < 100);
    v[0] = 1'b0;
    a1 = done_cyc[0];
    repeat (16) step();
    chk("busy_before_abort", 32'(bsy[0]), 32'(1));
    rst_n = 1'b1;
    #1;
    chk("abort_outs", 32'({rdy[0], sck[0], sdt[0], bsy[0], dn[0]}), 32'(5'b10000));
    repeat (2) step();
    rst_n = 1'b0;
    repeat (2) step();
    chk("abort_no_done", 32'(done_cyc[0]), 32'(a1));
    load(0, 12'h69B, 1'b0);
    chk("post_abort_chain", 32'(chain0), 32'(12'h69B));

    // Readback of a preloaded chain
    pre_val = 12'h3C6;
    pre_ld = 1'b1;
    #1 pre_ld = 1'b0;
    load(0, 12'h000, 1'b0);
    chk("zero_chain", 32'(chain0), 32'(12'h000));
`ifdef SHIFTER_READBACK_EN
    chk("readback_3c6", 32'(rd_done[0]), 32'(12'h3C6));
`endif

    // Random traffic on both instances
    for (int n = 0; n < 1500; n++) begin
      v[0] = ($urandom_range(0, 3) == 0);
      v[1] = ($urandom_range(0, 2) == 0);
      d[0] = W'($urandom);
      d[1] = W'($urandom);
      step();
    end
    v[0] = 1'b0;
    v[1] = 1'b0;
    repeat (80) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
